// File: rtl/pipelined_multiplier_hs.sv
// Parametrised multiplier pipeline with valid/ready handshake, per-stage bubble
// collapsing and an opaque tag carried alongside each product.
module pipelined_multiplier_hs #(
    parameter int WIDTH        = 32,
    parameter int LATENCY      = 8,
    parameter int SIGNED       = 0,
    parameter int FULL_PRODUCT = 0,
    parameter int TAG_WIDTH    = 4
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    input  logic [WIDTH-1:0]                                     a,
    input  logic [WIDTH-1:0]                                     b,
    input  logic [TAG_WIDTH-1:0]                                 in_tag,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [((FULL_PRODUCT != 0) ? 2*WIDTH : WIDTH)-1:0]   out,
    output logic [TAG_WIDTH-1:0]                                 out_tag,
    output logic                                                 busy
);

    localparam int RW = (FULL_PRODUCT != 0) ? 2*WIDTH : WIDTH;

    // Full 2*WIDTH product, then keep the low RW bits; low bits are identical
    // for signed and unsigned operands, only the upper half differs.
    function automatic logic [RW-1:0] product_trunc(input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
        logic signed [2*WIDTH-1:0] sx;
        logic signed [2*WIDTH-1:0] sy;
        logic        [2*WIDTH-1:0] p;
        if (SIGNED != 0) begin
            sx = {{WIDTH{x[WIDTH-1]}}, x};
            sy = {{WIDTH{y[WIDTH-1]}}, y};
            p  = sx * sy;
        end else begin
            sx = '0;
            sy = '0;
            p  = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
        end
        return p[RW-1:0];
    endfunction

    logic [RW-1:0]        w_prod_p0;
    logic [LATENCY:1]     w_en;
    logic [LATENCY:1]     r_vld;
    logic [RW-1:0]        r_data [1:LATENCY];
    logic [TAG_WIDTH-1:0] r_tag  [1:LATENCY];

    assign w_prod_p0 = product_trunc(a, b);

    // A stage may load when it is empty or when everything downstream of it
    // can move; written as a scan over valids to keep the chain acyclic.
    always_comb begin
        for (int k = 1; k <= LATENCY; k++) begin
            w_en[k] = out_ready;
            for (int j = k; j <= LATENCY; j++) begin
                if (!r_vld[j]) begin
                    w_en[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int k = 1; k <= LATENCY; k++) begin
                r_data[k] <= '0;
                r_tag[k]  <= '0;
            end
        end else begin
            // Entry -> stage 1
            if (w_en[1]) begin
                r_vld[1]  <= in_valid;
                r_data[1] <= w_prod_p0;
                r_tag[1]  <= in_tag;
            end
            // Stage k-1 -> stage k
            for (int k = 2; k <= LATENCY; k++) begin
                if (w_en[k]) begin
                    r_vld[k]  <= r_vld[k-1];
                    r_data[k] <= r_data[k-1];
                    r_tag[k]  <= r_tag[k-1];
                end
            end
        end
    end

    assign in_ready  = w_en[1];
    assign out_valid = r_vld[LATENCY];
    assign out       = r_data[LATENCY];
    assign out_tag   = r_tag[LATENCY];
    assign busy      = |r_vld;

endmodule

// File: tb/tb_pipelined_multiplier_hs.sv
// Self-checking bench for pipelined_multiplier_hs: directed sequences, a constant
// vector table for signed/unsigned full products, and scoreboarded random traffic.
module tb_pipelined_multiplier_hs;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Default configuration: WIDTH=32, LATENCY=8, unsigned, truncated
    logic        iv0, ir0, ov0, or0, busy0;
    logic [31:0] a0, b0, out0;
    logic [3:0]  tg0, ot0;

    // WIDTH=8, LATENCY=1, signed, truncated
    logic        iv1, ir1, ov1, or1, busy1;
    logic [7:0]  a1, b1, out1;
    logic [3:0]  tg1, ot1;

    // WIDTH=8, LATENCY=2, full product; u2 signed, u3 unsigned, shared inputs
    logic        iv2, or2;
    logic [7:0]  a2, b2;
    logic [3:0]  tg2;
    logic        ir2, ov2, busy2, ir3, ov3, busy3;
    logic [15:0] out2, out3;
    logic [3:0]  ot2, ot3;

    pipelined_multiplier_hs u0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .in_tag(tg0), .out_valid(ov0), .out_ready(or0), .out(out0),
        .out_tag(ot0), .busy(busy0));

    pipelined_multiplier_hs #(.WIDTH(8), .LATENCY(1), .SIGNED(1), .FULL_PRODUCT(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .in_tag(tg1), .out_valid(ov1), .out_ready(or1), .out(out1),
        .out_tag(ot1), .busy(busy1));

    pipelined_multiplier_hs #(.WIDTH(8), .LATENCY(2), .SIGNED(1), .FULL_PRODUCT(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .in_tag(tg2), .out_valid(ov2), .out_ready(or2), .out(out2),
        .out_tag(ot2), .busy(busy2));

    pipelined_multiplier_hs #(.WIDTH(8), .LATENCY(2), .SIGNED(0), .FULL_PRODUCT(1)) u3 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir3), .a(a2), .b(b2),
        .in_tag(tg2), .out_valid(ov3), .out_ready(or2), .out(out3),
        .out_tag(ot3), .busy(busy3));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each accepted op is a FIFO entry {tag, a*b mod 2^RW}.
    // Sampled at negedge, i.e. the handshake values the next rising edge sees.
    logic [35:0] q0[$];
    logic [11:0] q1[$];
    int          pops0 = 0;
    bit          hold0 = 1'b0;
    logic [35:0] held0;
    bit          hold1 = 1'b0;
    logic [11:0] held1;

    always @(negedge clk) begin
        logic [63:0] p;
        logic [35:0] e;
        if (rst) begin
            q0.delete();
            hold0 = 1'b0;
        end else begin
            chk("busy0", busy0, q0.size() != 0);
            if (hold0) begin
                chk("hold_valid0", ov0, 1);
                chk("hold_data0", {ot0, out0}, held0);
            end
            if (ov0 && or0) begin
                if (q0.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out0_unexpected: got result %0h, expected no result", out0);
                end else begin
                    e = q0.pop_front();
                    chk("out0", {ot0, out0}, e);
                    pops0++;
                end
            end
            hold0 = ov0 && !or0;
            held0 = {ot0, out0};
            if (iv0 && ir0) begin
                p = {32'b0, a0} * {32'b0, b0};
                q0.push_back({tg0, p[31:0]});
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] p;
        logic [11:0] e;
        if (rst) begin
            q1.delete();
            hold1 = 1'b0;
        end else begin
            chk("busy1", busy1, q1.size() != 0);
            if (hold1) begin
                chk("hold_valid1", ov1, 1);
                chk("hold_data1", {ot1, out1}, held1);
            end
            if (ov1 && or1) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out1_unexpected: got result %0h, expected no result", out1);
                end else begin
                    e = q1.pop_front();
                    chk("out1", {ot1, out1}, e);
                end
            end
            hold1 = ov1 && !or1;
            held1 = {ot1, out1};
            if (iv1 && ir1) begin
                p = {8'b0, a1} * {8'b0, b1};
                q1.push_back({tg1, p[7:0]});
            end
        end
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_s;
        logic [15:0] exp_u;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int stale;
        int p_before;
        bit found;

        tbl[0] = '{8'hFF, 8'h02, 16'hFFFE, 16'h01FE};
        tbl[1] = '{8'h80, 8'h80, 16'h4000, 16'h4000};
        tbl[2] = '{8'h80, 8'h7F, 16'hC080, 16'h3F80};
        tbl[3] = '{8'hFF, 8'hFF, 16'h0001, 16'hFE01};
        tbl[4] = '{8'h00, 8'h5A, 16'h0000, 16'h0000};
        tbl[5] = '{8'h7F, 8'h7F, 16'h3F01, 16'h3F01};

        rst = 1'b1;
        iv0 = 0; a0 = 0; b0 = 0; tg0 = 0; or0 = 1;
        iv1 = 0; a1 = 0; b1 = 0; tg1 = 0; or1 = 1;
        iv2 = 0; a2 = 0; b2 = 0; tg2 = 0; or2 = 1;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_out_valid", ov0, 0);
        chk("rst_out", out0, 0);
        chk("rst_out_tag", ot0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_in_ready", ir0, 1);
        chk("rst_out_valid_l1", ov1, 0);
        chk("rst_out_valid_fp", ov2, 0);

        // Single op: valid exactly 8 cycles after presentation, one cycle wide
        iv0 = 1; a0 = 7; b0 = 6; tg0 = 3;
        for (int c = 1; c <= 10; c++) begin
            tick();
            iv0 = 0;
            chk($sformatf("lat8_valid_c%0d", c), ov0, c == 8);
            if (c == 8) begin
                chk("lat8_out", out0, 42);
                chk("lat8_tag", ot0, 3);
            end
        end

        // Back-to-back stream at full throughput
        p_before = pops0;
        for (int i = 0; i < 20; i++) begin
            iv0 = 1; a0 = 32'(i); b0 = 32'(i + 1); tg0 = 4'(i);
            chk("stream_in_ready", ir0, 1);
            tick();
        end
        iv0 = 0;
        repeat (8) tick();
        chk("stream_count", pops0 - p_before, 20);
        chk("stream_idle", busy0, 0);

        // Backpressure: exactly LATENCY ops accepted while the consumer stalls
        or0 = 0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            iv0 = 1; a0 = $urandom; b0 = $urandom; tg0 = 4'($urandom);
            @(negedge clk);
            if (ir0) acc++;
            tick();
        end
        chk("bp_accepted", acc, 8);
        chk("bp_in_ready", ir0, 0);
        chk("bp_busy", busy0, 1);

        // Full pipe with consumer ready: accept and emit in the same cycle
        or0 = 1;
        #1;
        chk("full_in_ready", ir0, 1);
        for (int i = 0; i < 5; i++) begin
            iv0 = 1; a0 = $urandom; b0 = $urandom; tg0 = 4'($urandom);
            chk("full_shift_ready", ir0, 1);
            tick();
            chk("full_occupancy", q0.size(), 8);
            chk("full_out_valid", ov0, 1);
        end
        iv0 = 0;
        repeat (12) tick();
        chk("bp_drained", q0.size(), 0);
        chk("bp_drain_idle", busy0, 0);

        // Truncated 32-bit product wrapping to zero, plus a wrapping edge value
        iv0 = 1; a0 = 32'h0001_0000; b0 = 32'h0001_0000; tg0 = 4'hA;
        tick();
        iv0 = 1; a0 = 32'hFFFF_FFFF; b0 = 32'h0000_0002; tg0 = 4'hB;
        tick();
        iv0 = 0;
        repeat (6) tick();
        chk("trunc_valid", ov0, 1);
        chk("trunc_zero", out0, 0);
        tick();
        chk("trunc_wrap", out0, 32'hFFFF_FFFE);
        tick();

        // Reset with 5 ops in flight; input offered during reset must be dropped
        or0 = 0;
        for (int i = 0; i < 5; i++) begin
            iv0 = 1; a0 = $urandom; b0 = $urandom; tg0 = 4'(i);
            tick();
        end
        iv0 = 1; a0 = 32'hDEAD; b0 = 32'h1; tg0 = 4'hD;
        rst = 1;
        tick();
        rst = 0;
        iv0 = 0;
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_out_valid", ov0, 0);
        chk("mid_rst_out", out0, 0);
        chk("mid_rst_out_tag", ot0, 0);
        chk("mid_rst_in_ready", ir0, 1);
        or0 = 1;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ov0) stale++;
        end
        chk("mid_rst_no_stale", stale, 0);

        // Full-product vector table, signed and unsigned side by side
        for (int r = 0; r < 6; r++) begin
            iv2 = 1; a2 = tbl[r].a; b2 = tbl[r].b; tg2 = 4'(r);
            tick();
            iv2 = 0;
            found = 0;
            for (int c = 0; c < 6 && !found; c++) begin
                tick();
                found = ov2;
            end
            chk($sformatf("tbl%0d_valid", r), found, 1);
            chk($sformatf("tbl%0d_valid_u", r), ov3, 1);
            chk($sformatf("tbl%0d_signed", r), out2, tbl[r].exp_s);
            chk($sformatf("tbl%0d_unsigned", r), out3, tbl[r].exp_u);
            chk($sformatf("tbl%0d_tag", r), ot2, r);
        end
        tick();

        // LATENCY=1: result one cycle after presentation
        iv1 = 1; a1 = 3; b1 = 5; tg1 = 9;
        tick();
        iv1 = 0;
        chk("l1_valid", ov1, 1);
        chk("l1_out", out1, 15);
        chk("l1_tag", ot1, 9);
        tick();
        chk("l1_one_wide", ov1, 0);

        // Random traffic with random consumer stalls
        acc = 0;
        for (int cyc = 0; cyc < 8000 && acc < 1000; cyc++) begin
            iv1 = 1'($urandom_range(0, 1));
            a1 = 8'($urandom); b1 = 8'($urandom); tg1 = 4'($urandom);
            or1 = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (iv1 && ir1) acc++;
            tick();
        end
        chk("rand_ops", acc, 1000);
        iv1 = 0; or1 = 1;
        repeat (4) tick();
        chk("rand_drained", q1.size(), 0);
        chk("rand_idle", busy1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
